// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the parametrised serial-pattern detector.
package seq_detect_pkg;

  localparam logic [4:0] DEF_PAT_10001 = 5'b10001;

  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;

  // Width needed to hold a count of 0..n inclusive.
  function automatic int st_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Bit-stream, control and status bundle between the bit source and the detector.
interface seq_detect_param_if #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8,
  parameter int ST_W  = 3
);

  logic             en;
  logic             din;
  logic             overlap;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             cnt_clr;
  logic             dout;
  logic [ST_W-1:0]  stat;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output en, din, overlap, pat_load, pat_in, cnt_clr,
    input  dout, stat, match_cnt
  );

  modport slave (
    input  en, din, overlap, pat_load, pat_in, cnt_clr,
    output dout, stat, match_cnt
  );

endinterface

// File: rtl/seq_prefix_match.sv
// Combinational prefix matcher: longest pattern prefix that equals the newest
// bits of the stream, plus the full-pattern match flag.
module seq_prefix_match #(
  parameter int PAT_W = 5,
  parameter int ST_W  = 3
) (
  input  logic [PAT_W-1:0] hist_n,
  input  logic [ST_W-1:0]  fill_n,
  input  logic [PAT_W-1:0] pattern,
  output logic             match_n,
  output logic [ST_W-1:0]  plen
);

  logic [PAT_W-1:0] hit;

  // hit[k-1]: the k newest bits equal the first k pattern bits (MSB first)
  for (genvar k = 1; k <= PAT_W; k++) begin : g_prefix
    assign hit[k-1] = (fill_n >= ST_W'(k)) &&
                      (hist_n[k-1:0] == pattern[PAT_W-1 -: k]);
  end

  always_comb begin
    plen = '0;
    for (int k = 1; k <= PAT_W; k++) begin
      if (hit[k-1]) plen = ST_W'(k);
    end
  end

  assign match_n = hit[PAT_W-1];

endmodule

// File: rtl/seq_detect_param.sv
// Moore serial-pattern detector with loadable pattern, selectable overlap and
// a saturating match counter; every output comes straight from a flop.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PAT_RST = DEF_PAT_10001,
  parameter int               CNT_W   = 8,
  parameter int               ST_W    = st_width(PAT_W)
) (
  input logic               clk,
  input logic               clr,
  seq_detect_param_if.slave bus
);

  localparam logic [ST_W-1:0]  FULL    = ST_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] pattern, pattern_d;
  logic [PAT_W-1:0] hist, hist_d, hist_n;
  logic [ST_W-1:0]  fill, fill_d, fill_n;
  logic [ST_W-1:0]  stat, stat_d, plen;
  logic             dout, dout_d, match_n, inc;
  logic [CNT_W-1:0] cnt, cnt_d;

  assign hist_n = {hist[PAT_W-2:0], bus.din};
  assign fill_n = (fill == FULL) ? FULL : fill + 1'b1;

  seq_prefix_match #(
    .PAT_W (PAT_W),
    .ST_W  (ST_W)
  ) u_match (
    .hist_n  (hist_n),
    .fill_n  (fill_n),
    .pattern (pattern),
    .match_n (match_n),
    .plen    (plen)
  );

  // pat_load outranks en so the bit arriving with a load is thrown away
  always_comb begin
    pattern_d = pattern;
    hist_d    = hist;
    fill_d    = fill;
    stat_d    = stat;
    dout_d    = 1'b0;
    inc       = 1'b0;
    if (bus.pat_load) begin
      pattern_d = bus.pat_in;
      hist_d    = '0;
      fill_d    = '0;
      stat_d    = '0;
    end else if (bus.en) begin
      inc    = match_n;
      dout_d = match_n;
      if (match_n && (bus.overlap == OVL_OFF)) begin
        hist_d = '0;
        fill_d = '0;
        stat_d = '0;
      end else begin
        hist_d = hist_n;
        fill_d = fill_n;
        stat_d = plen;
      end
    end
  end

  always_comb begin
    cnt_d = cnt;
    if (bus.cnt_clr)                 cnt_d = '0;
    else if (inc && (cnt != CNT_MAX)) cnt_d = cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pattern <= PAT_RST;
      hist    <= '0;
      fill    <= '0;
      stat    <= '0;
      dout    <= 1'b0;
      cnt     <= '0;
    end else begin
      pattern <= pattern_d;
      hist    <= hist_d;
      fill    <= fill_d;
      stat    <= stat_d;
      dout    <= dout_d;
      cnt     <= cnt_d;
    end
  end

  assign bus.dout      = dout;
  assign bus.stat      = stat;
  assign bus.match_cnt = cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench: default detector plus a 2-bit-counter copy fed the same stream.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   passCount  = 0;
  int   totalCount = 0;

  always #5 clk = ~clk;

  seq_detect_param_if #(.PAT_W(5), .CNT_W(8), .ST_W(3)) bus_a ();
  seq_detect_param_if #(.PAT_W(5), .CNT_W(2), .ST_W(3)) bus_b ();

  seq_detect_param #(.PAT_W(5), .PAT_RST(5'b10001), .CNT_W(8), .ST_W(3)) dut_a (
    .clk (clk),
    .clr (clr),
    .bus (bus_a.slave)
  );

  seq_detect_param #(.PAT_W(5), .PAT_RST(5'b10001), .CNT_W(2), .ST_W(3)) dut_b (
    .clk (clk),
    .clr (clr),
    .bus (bus_b.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  // Drive one cycle on both detectors at the falling edge, sample 1 after the rise.
  task automatic applyStimulus(input logic e, input logic d, input logic ovl,
                               input logic pl, input logic [4:0] pi, input logic cc);
    @(negedge clk);
    bus_a.en = e; bus_a.din = d; bus_a.overlap = ovl;
    bus_a.pat_load = pl; bus_a.pat_in = pi; bus_a.cnt_clr = cc;
    bus_b.en = e; bus_b.din = d; bus_b.overlap = ovl;
    bus_b.pat_load = pl; bus_b.pat_in = pi; bus_b.cnt_clr = cc;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    clr = 1'b0;
    bus_a.en = 1'b0; bus_a.pat_load = 1'b0; bus_a.cnt_clr = 1'b0;
    bus_b.en = 1'b0; bus_b.pat_load = 1'b0; bus_b.cnt_clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
  endtask

  logic [8:0] stream9 = 9'b100010001;
  logic [4:0] pat10001 = 5'b10001;
  logic [4:0] pat11011 = 5'b11011;
  int expStatOvl [9] = '{1, 2, 3, 4, 5, 2, 3, 4, 5};
  int expStatNon [9] = '{1, 2, 3, 4, 0, 0, 0, 0, 1};
  int expStatNew [5] = '{1, 2, 3, 4, 5};

  initial begin
    bus_a.en = 0; bus_a.din = 0; bus_a.overlap = 1; bus_a.pat_load = 0;
    bus_a.pat_in = 0; bus_a.cnt_clr = 0;
    bus_b.en = 0; bus_b.din = 0; bus_b.overlap = 1; bus_b.pat_load = 0;
    bus_b.pat_in = 0; bus_b.cnt_clr = 0;
    #12;
    checkOutput("reset_dout", 32'(bus_a.dout), 0);
    checkOutput("reset_stat", 32'(bus_a.stat), 0);
    checkOutput("reset_cnt", 32'(bus_a.match_cnt), 0);
    clr = 1'b1;

    // Overlapping: 1,0,0,0,1,0,0,0,1
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, stream9[8-i], 1, 0, 0, 0);
      checkOutput($sformatf("ovl_stat_%0d", i+1), 32'(bus_a.stat), 32'(expStatOvl[i]));
      checkOutput($sformatf("ovl_dout_%0d", i+1), 32'(bus_a.dout),
                  (i == 4 || i == 8) ? 32'd1 : 32'd0);
    end
    checkOutput("ovl_cnt", 32'(bus_a.match_cnt), 2);

    // Non-overlapping on the same stream
    doReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, stream9[8-i], 0, 0, 0, 0);
      checkOutput($sformatf("non_stat_%0d", i+1), 32'(bus_a.stat), 32'(expStatNon[i]));
      checkOutput($sformatf("non_dout_%0d", i+1), 32'(bus_a.dout), (i == 4) ? 32'd1 : 32'd0);
    end
    checkOutput("non_cnt", 32'(bus_a.match_cnt), 1);

    // Five back-to-back non-overlapping matches: 2-bit counter saturates
    doReset();
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < 5; i++)
        applyStimulus(1, pat10001[4-i], 0, 0, 0, 0);
    checkOutput("sat_cnt_w2", 32'(bus_b.match_cnt), 3);
    checkOutput("sat_cnt_w8", 32'(bus_a.match_cnt), 5);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("cnt_clr_w2", 32'(bus_b.match_cnt), 0);
    checkOutput("cnt_clr_w8", 32'(bus_a.match_cnt), 0);
    checkOutput("cnt_clr_stat", 32'(bus_a.stat), 0);

    // en gaps freeze progress
    doReset();
    applyStimulus(1, 1, 1, 0, 0, 0); checkOutput("gap_stat_b1", 32'(bus_a.stat), 1);
    applyStimulus(0, 0, 1, 0, 0, 0); checkOutput("gap_stat_g1", 32'(bus_a.stat), 1);
    applyStimulus(1, 0, 1, 0, 0, 0); checkOutput("gap_stat_b2", 32'(bus_a.stat), 2);
    applyStimulus(1, 0, 1, 0, 0, 0); checkOutput("gap_stat_b3", 32'(bus_a.stat), 3);
    applyStimulus(0, 1, 1, 0, 0, 0); checkOutput("gap_stat_g2", 32'(bus_a.stat), 3);
    checkOutput("gap_dout_g2", 32'(bus_a.dout), 0);
    applyStimulus(1, 0, 1, 0, 0, 0); checkOutput("gap_stat_b4", 32'(bus_a.stat), 4);
    checkOutput("gap_dout_b4", 32'(bus_a.dout), 0);
    applyStimulus(1, 1, 1, 0, 0, 0); checkOutput("gap_stat_b5", 32'(bus_a.stat), 5);
    checkOutput("gap_dout_b5", 32'(bus_a.dout), 1);
    applyStimulus(0, 0, 1, 0, 0, 0); checkOutput("gap_dout_after", 32'(bus_a.dout), 0);
    checkOutput("gap_cnt", 32'(bus_a.match_cnt), 1);

    // Pattern reload mid-prefix
    doReset();
    applyStimulus(1, 1, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    checkOutput("load_pre_stat", 32'(bus_a.stat), 3);
    applyStimulus(1, 1, 1, 1, pat11011, 0);
    checkOutput("load_stat", 32'(bus_a.stat), 0);
    checkOutput("load_dout", 32'(bus_a.dout), 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, pat11011[4-i], 1, 0, 0, 0);
      checkOutput($sformatf("new_stat_%0d", i+1), 32'(bus_a.stat), 32'(expStatNew[i]));
      checkOutput($sformatf("new_dout_%0d", i+1), 32'(bus_a.dout), (i == 4) ? 32'd1 : 32'd0);
    end
    checkOutput("new_cnt", 32'(bus_a.match_cnt), 1);

    // Asynchronous reset mid-stream
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1, pat10001[4-i], 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    checkOutput("arst_pre_stat", 32'(bus_a.stat), 4);
    checkOutput("arst_pre_cnt", 32'(bus_a.match_cnt), 1);
    @(negedge clk);
    #1 clr = 1'b0;
    #1;
    checkOutput("arst_stat", 32'(bus_a.stat), 0);
    checkOutput("arst_cnt", 32'(bus_a.match_cnt), 0);
    checkOutput("arst_dout", 32'(bus_a.dout), 0);
    #1 clr = 1'b1;
    applyStimulus(1, 1, 1, 0, 0, 0);
    checkOutput("arst_post_stat", 32'(bus_a.stat), 1);
    checkOutput("arst_post_dout", 32'(bus_a.dout), 0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
